// File: rtl/avalon_pio_pkg.sv
// Shared constants for the extended Avalon PIO: register map, capture-edge selection
// and the debounce counter width helper.
package avalon_pio_pkg;

    typedef enum logic [2:0] {
        ADDR_DATA   = 3'd0,
        ADDR_OUT    = 3'd1,
        ADDR_MASK   = 3'd2,
        ADDR_EDGE   = 3'd3,
        ADDR_OUTSET = 3'd4,
        ADDR_OUTCLR = 3'd5
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // The counter only needs to hold DEBOUNCE_CYC-1.
    function automatic int deb_cnt_w(input int cyc);
        return (cyc <= 2) ? 1 : $clog2(cyc);
    endfunction

endpackage

// File: rtl/avalon_pio_ext_if.sv
// Avalon-MM slave bus bundle (32-bit data, 3-bit word address) for the PIO.
interface avalon_pio_ext_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport slave  (input address, chipselect, write_n, writedata, output readdata);
    modport master (output address, chipselect, write_n, writedata, input readdata);
endinterface

// File: rtl/pio_debounce.sv
// Single-bit input filter: output follows the input only after CYC stable samples.
// Present only when AVALON_PIO_DEBOUNCE_EN is defined.
`ifdef AVALON_PIO_DEBOUNCE_EN
module pio_debounce
    import avalon_pio_pkg::*;
#(
    parameter int CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);
    localparam int            CW     = deb_cnt_w(CYC);
    localparam logic [CW-1:0] RELOAD = CW'(CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;

    // A sample that matches the output restarts the window, so any bounce back resets it.
    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        if (d_i == q_q) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            q_d   = d_i;
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= RELOAD;
            q_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
        end
    end

    assign q_o = q_q;
endmodule
`endif

// File: rtl/avalon_pio_ext.sv
// Avalon-MM PIO with set/clear output, synchronised input, edge capture and masked IRQ.
// Optional input debounce is enabled with AVALON_PIO_DEBOUNCE_EN.
module avalon_pio_ext
    import avalon_pio_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] OUT_RESET    = '0,
    parameter int                EDGE_TYPE    = EDGE_RISE,
    parameter int                DEBOUNCE_CYC = 16
) (
    input  logic                clk,
    input  logic                reset,
    avalon_pio_ext_if.slave     bus,
    input  logic [DATA_W-1:0]   in_port,
    output logic [DATA_W-1:0]   out_port,
    output logic                irq
);
    logic [DATA_W-1:0] s1_q, s2_q, s3_q, filt, edge_det;
    logic [DATA_W-1:0] out_q, out_d, mask_q, mask_d, cap_q, cap_d;
    logic              irq_q, irq_d;
    logic              wr;
    logic [DATA_W-1:0] wd;
    logic [31:0]       rd;
    logic              unused_wd;

    assign wr        = bus.chipselect & ~bus.write_n;
    assign wd        = bus.writedata[DATA_W-1:0];
    assign unused_wd = ^bus.writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= in_port;
            s2_q <= s1_q;
            s3_q <= filt;
        end
    end

`ifdef AVALON_PIO_DEBOUNCE_EN
    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_deb
        pio_debounce #(.CYC(DEBOUNCE_CYC)) u_deb (
            .clk   (clk),
            .reset (reset),
            .d_i   (s2_q[gi]),
            .q_o   (filt[gi])
        );
    end
`else
    assign filt = s2_q;
`endif

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_det = ~filt & s3_q;
            EDGE_ANY:  edge_det = filt ^ s3_q;
            default:   edge_det = filt & ~s3_q;
        endcase
    end

    // New edges are ORed in after the write-1-to-clear, so a coincident set wins.
    always_comb begin
        out_d  = out_q;
        mask_d = mask_q;
        cap_d  = cap_q | edge_det;
        irq_d  = |(cap_q & mask_q);
        if (wr) begin
            case (pio_addr_e'(bus.address))
                ADDR_OUT:    out_d  = wd;
                ADDR_MASK:   mask_d = wd;
                ADDR_EDGE:   cap_d  = (cap_q & ~wd) | edge_det;
                ADDR_OUTSET: out_d  = out_q | wd;
                ADDR_OUTCLR: out_d  = out_q & ~wd;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= OUT_RESET;
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        rd = '0;
        case (pio_addr_e'(bus.address))
            ADDR_DATA: rd[DATA_W-1:0] = filt;
            ADDR_OUT:  rd[DATA_W-1:0] = out_q;
            ADDR_MASK: rd[DATA_W-1:0] = mask_q;
            ADDR_EDGE: rd[DATA_W-1:0] = cap_q;
            default:   rd = '0;
        endcase
    end

    assign bus.readdata = rd;
    assign out_port     = out_q;
    assign irq          = irq_q;
endmodule

// File: tb/tb_avalon_pio_ext.sv
// Directed plus randomized bench for avalon_pio_ext against a cycle-level reference model.
module tb_avalon_pio_ext;
    import avalon_pio_pkg::*;

    localparam int         DW   = 8;
    localparam logic [7:0] ORST = 8'hA5;
    localparam int         C    = 4;
`ifdef AVALON_PIO_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = C;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in_port;
    logic [DW-1:0] out_port;
    logic          irq;

    avalon_pio_ext_if bus();

    avalon_pio_ext #(
        .DATA_W       (DW),
        .OUT_RESET    (ORST),
        .EDGE_TYPE    (EDGE_RISE),
        .DEBOUNCE_CYC (C)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .in_port  (in_port),
        .out_port (out_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: register contents plus the recent history of in_port values.
    logic [7:0] m_out, m_mask, m_cap, m_in1, m_in2, m_fq, m_fprev;
    logic       m_irq;
    logic [7:0] m_s2h[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = ORST; m_mask = 0; m_cap = 0; m_in1 = 0; m_in2 = 0;
        m_fq = 0; m_fprev = 0; m_irq = 0;
        m_s2h.delete();
        for (int i = 0; i < C; i++) m_s2h.push_back(8'h00);
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {24'b0, (DEB ? m_fq : m_in2)};
            3'd1:    return {24'b0, m_out};
            3'd2:    return {24'b0, m_mask};
            3'd3:    return {24'b0, m_cap};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_edge(input bit we, input logic [2:0] a, input logic [31:0] d,
                              input logic [7:0] inp);
        logic [7:0] f_cur, ev, wv, all1, all0;
        f_cur = DEB ? m_fq : m_in2;
        ev    = f_cur & ~m_fprev;
        wv    = d[7:0];
        m_irq = |(m_cap & m_mask);
        m_cap = (m_cap & ~((we && a == 3'd3) ? wv : 8'h00)) | ev;
        if (we && a == 3'd1) m_out  = wv;
        if (we && a == 3'd4) m_out  = m_out | wv;
        if (we && a == 3'd5) m_out  = m_out & ~wv;
        if (we && a == 3'd2) m_mask = wv;
        if (DEB) begin
            m_s2h.push_back(m_in2);
            if (m_s2h.size() > C) void'(m_s2h.pop_front());
            all1 = 8'hFF; all0 = 8'hFF;
            foreach (m_s2h[j]) begin
                all1 = all1 & m_s2h[j];
                all0 = all0 & ~m_s2h[j];
            end
            m_fq = (m_fq | all1) & ~all0;
        end
        m_fprev = f_cur;
        m_in2   = m_in1;
        m_in1   = inp;
    endtask

    task automatic step(input bit we, input logic [2:0] a, input logic [31:0] d,
                        input logic [7:0] inp, input logic [2:0] ra);
        bus.chipselect = we;
        bus.write_n    = ~we;
        bus.address    = a;
        bus.writedata  = d;
        in_port        = inp;
        @(posedge clk);
        model_edge(we, a, d, inp);
        #1;
        chk("out_port", {24'b0, out_port}, {24'b0, m_out});
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = ra;
        #1;
        chk($sformatf("readdata@%0d", ra), bus.readdata, m_read(ra));
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        chk(tag, bus.readdata, exp);
    endtask

    initial begin
        logic [7:0] inp;
        reset          = 1'b1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        in_port        = 8'h00;
        model_reset();
        #2;
        chk("rst_out", {24'b0, out_port}, 32'h0000_00A5);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_hold", {24'b0, out_port}, 32'h0000_00A5);
        reset = 1'b0;
        rd_chk("rst_rd_out", 3'd1, 32'h0000_00A5);
        rd_chk("rst_rd_edge", 3'd3, 32'h0);

        // output register, set and clear
        step(1, 3'd1, 32'hFFFF_FF0F, 8'h00, 3'd1);
        chk("out_wr", {24'b0, out_port}, 32'h0F);
        step(1, 3'd4, 32'h0000_00F0, 8'h00, 3'd4);
        chk("out_set", {24'b0, out_port}, 32'hFF);
        chk("rd_outset_zero", bus.readdata, 32'h0);
        step(1, 3'd5, 32'h0000_0081, 8'h00, 3'd5);
        chk("out_clr", {24'b0, out_port}, 32'h7E);
        chk("rd_outclr_zero", bus.readdata, 32'h0);
        rd_chk("rd_out_7e", 3'd1, 32'h7E);
        step(1, 3'd6, 32'hFFFF_FFFF, 8'h00, 3'd6);
        chk("wr6_ignored", {24'b0, out_port}, 32'h7E);

        // bit2 rising edge, masked in
        step(1, 3'd2, 32'h04, 8'h00, 3'd2);
        step(0, 3'd0, 0, 8'h04, 3'd3);                 // edge k
        repeat (1 + LAT) step(0, 3'd0, 0, 8'h04, 3'd3);
        chk("edge_not_yet", bus.readdata, 32'h0);
        step(0, 3'd0, 0, 8'h04, 3'd3);                 // edge k+2
        chk("edge_set", bus.readdata, 32'h04);
        chk("irq_not_yet", {31'b0, irq}, 32'h0);
        step(0, 3'd0, 0, 8'h04, 3'd3);                 // edge k+3
        chk("irq_set", {31'b0, irq}, 32'h1);
        rd_chk("data_bit2", 3'd0, 32'h04);
        step(1, 3'd3, 32'h04, 8'h04, 3'd3);
        chk("edge_cleared", bus.readdata, 32'h0);
        chk("irq_lags_clear", {31'b0, irq}, 32'h1);
        step(0, 3'd0, 0, 8'h04, 3'd3);
        chk("irq_dropped", {31'b0, irq}, 32'h0);

        // capture coinciding with write-1-to-clear
        repeat (LAT + 4) step(0, 3'd0, 0, 8'h00, 3'd3);
        step(0, 3'd0, 0, 8'h04, 3'd3);
        repeat (1 + LAT) step(0, 3'd0, 0, 8'h04, 3'd3);
        step(1, 3'd3, 32'h04, 8'h04, 3'd3);
        chk("set_wins", bus.readdata, 32'h04);
        step(0, 3'd0, 0, 8'h04, 3'd3);
        chk("set_wins_irq", {31'b0, irq}, 32'h1);

        // masked capture, then unmask
        step(1, 3'd3, 32'hFF, 8'h04, 3'd3);
        step(1, 3'd2, 32'h00, 8'h04, 3'd3);
        repeat (LAT + 4) step(0, 3'd0, 0, 8'h05, 3'd3);
        chk("masked_edge", bus.readdata, 32'h01);
        chk("masked_irq", {31'b0, irq}, 32'h0);
        step(1, 3'd2, 32'h01, 8'h05, 3'd2);
        chk("unmask_lag", {31'b0, irq}, 32'h0);
        step(0, 3'd0, 0, 8'h05, 3'd3);
        chk("unmask_irq", {31'b0, irq}, 32'h1);

        // reset in the middle of a cycle
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        chk("midrst_out", {24'b0, out_port}, 32'hA5);
        rd_chk("midrst_edge", 3'd3, 32'h0);
        rd_chk("midrst_mask", 3'd2, 32'h0);
        @(negedge clk);
        reset = 1'b0;

`ifdef AVALON_PIO_DEBOUNCE_EN
        repeat (C + 4) step(0, 3'd0, 0, 8'h00, 3'd0);
        step(1, 3'd3, 32'hFF, 8'h00, 3'd0);
        repeat (3) step(0, 3'd0, 0, 8'h02, 3'd0);
        repeat (C + 4) step(0, 3'd0, 0, 8'h00, 3'd0);
        chk("glitch_data", bus.readdata, 32'h0);
        rd_chk("glitch_edge", 3'd3, 32'h0);
        repeat (C + 4) step(0, 3'd0, 0, 8'h02, 3'd0);
        chk("stable_data", bus.readdata, 32'h02);
        rd_chk("stable_edge", 3'd3, 32'h02);
`endif

        // randomized traffic against the model
        inp = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) inp = 8'($urandom);
            step(bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                 inp, 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/avalon_pio_ext.md
Name: avalon_pio_ext

Overview:
- Parametrised successor to the single-register output PIO. Avalon-MM slave with:
  - an output port supporting atomic bit set/clear;
  - a synchronised input port;
  - per-bit edge capture and an interrupt mask;
  - a level interrupt to the Nios II IRQ controller.
- Sits on the system interconnect beside the other PIO slaves.
- Drives LEDs/strobes and samples pushbuttons/switches.

Parameters:
- DATA_W, 8, width of in_port/out_port; legal 1..32.
- OUT_RESET, 0, reset value of the output register (DATA_W bits).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 either.
- DEBOUNCE_CYC, 16, stable-sample count for the optional debounce; legal 2..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits above DATA_W ignored
- readdata  out  32  read data; bits above DATA_W are zero
- in_port  in  DATA_W  asynchronous external inputs
- out_port  out  DATA_W  output register
- irq  out  1  level interrupt, active high

Behaviour:
- Reset is asynchronous, active-high; deassertion is synchronous to clk. Reset values:
  - out_reg = OUT_RESET
  - irq_mask = 0
  - edge_cap = 0
  - sync stages = 0
  - irq = 0
- Reset mid-operation clears all state immediately. No pending capture survives reset.
- A write occurs on a cycle with chipselect=1 and write_n=0. Register map by address:
  - 0 DATA: read = in_sync (filtered value if debounce enabled); write ignored.
  - 1 OUT: read/write out_reg.
  - 2 MASK: read/write irq_mask.
  - 3 EDGE: read edge_cap; write-1-to-clear per bit.
  - 4 OUTSET: out_reg |= wd; reads 0.
  - 5 OUTCLR: out_reg &= ~wd; reads 0.
  - 6, 7: reads 0; writes ignored.
- readdata is combinational from address and current register state (zero wait states, read latency 0). Reads have no side effects.
- out_port = out_reg. A write takes effect on out_port at the clock edge that samples the write.
- Input path:
  - in_port passes through 2 flops (s1, s2); s3 holds the previous s2.
  - edge = s2&~s3 (type 0), ~s2&s3 (type 1), or s2^s3 (type 2).
  - An in_port change setting up before edge k appears in s2 after edge k+1. edge_cap sets at edge k+2.
- edge_cap[i] is sticky until cleared by software or reset.
- Simultaneous new edge and write-1-to-clear on the same bit: set wins, bit stays 1. Other bits clear normally.
- irq is registered: irq <= |(edge_cap & irq_mask). It asserts one cycle after edge_cap sets (edge k+3).
- irq also asserts one cycle after unmasking an already-set bit. It deasserts one cycle after the clear or mask write.
- DATA_W=32: all 32 writedata bits are used. Widths below 32 truncate writedata and zero-extend readdata.

Optional Feature:
- Macro AVALON_PIO_DEBOUNCE_EN.
- Defined:
  - Each s2 bit feeds a counter.
  - The filtered bit takes the s2 value only after s2 has been constant for DEBOUNCE_CYC consecutive cycles.
  - Any change restarts the count.
  - Edge detection and DATA reads use the filtered bit, adding DEBOUNCE_CYC cycles of latency.
  - Filtered value resets to 0.
- Undefined: no counters; the filtered value equals s2 directly.

Decomposition:
- Shared package avalon_pio_pkg holds:
  - address constants ADDR_DATA..ADDR_OUTCLR;
  - EDGE_RISE/EDGE_FALL/EDGE_ANY constants;
  - counter width derived from DEBOUNCE_CYC via $clog2.
- One sub-module, pio_debounce: a single-bit filter instantiated DATA_W times under generate. It exists only when AVALON_PIO_DEBOUNCE_EN is defined.

Test Plan:
- Reset, DATA_W=8, OUT_RESET=8'hA5:
  - out_port=0xA5 during reset and after release; irq=0.
  - Read address 1 returns 0x000000A5.
- Write 0x0F to OUT, then 0xF0 to OUTSET, then 0x81 to OUTCLR: out_port is 0x0F, then 0xFF, then 0x7E, each on the sampling edge. Reads of addresses 4/5 return 0.
- EDGE_TYPE=0, MASK=0x04, in_port bit2 0->1 before edge k:
  - EDGE reads 0x04 after edge k+2; irq=1 after edge k+3.
  - Writing 0x04 to EDGE drops irq one cycle later.
- Simultaneous edge and clear: bit2 rises so that the capture edge coincides with a 0x04 write to EDGE. The bit stays set and irq stays/goes high.
- Masked capture:
  - MASK=0, bit0 rises: EDGE=0x01, irq stays 0.
  - Write MASK=0x01: irq=1 one cycle later.
  - Assert reset mid-sequence: EDGE=0, irq=0 immediately.
- AVALON_PIO_DEBOUNCE_EN, DEBOUNCE_CYC=4:
  - A 3-cycle glitch on bit1 produces no capture and DATA stays 0.
  - A 4-cycle stable high sets EDGE bit1; DATA reads 0x02.
